// File: rtl/p4bd_sync_receiver_if.sv
// rtl/p4bd_sync_receiver_if.sv - 4-phase bundled-data input channel plus clocked valid/ready output port
interface p4bd_sync_receiver_if #(
    parameter int WIDTH = 12
);
    logic             req;
    logic [WIDTH-1:0] data;
    logic             ack;
    logic [WIDTH-1:0] out_data;
    logic             out_valid;
    logic             out_ready;

    // master: the asynchronous sender plus the clocked consumer; slave: the receiver
    modport master (
        output req, data, out_ready,
        input  ack, out_data, out_valid
    );

    modport slave (
        input  req, data, out_ready,
        output ack, out_data, out_valid
    );
endinterface

// File: rtl/p4bd_sync_receiver.sv
// rtl/p4bd_sync_receiver.sv - clocked receiver terminating a 4-phase bundled-data channel into a 2-entry valid/ready FIFO
module p4bd_sync_receiver #(
    parameter int WIDTH       = 12,
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    p4bd_sync_receiver_if.slave  bus,
    output logic [CNT_W-1:0]     rx_count
);

    localparam logic [1:0] ST_RESYNC = 2'd0;
    localparam logic [1:0] ST_IDLE   = 2'd1;
    localparam logic [1:0] ST_HOLD   = 2'd2;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   req_s;
    logic [1:0]             state;
    logic                   ack_q;
    logic [WIDTH-1:0]       head_q;
    logic [WIDTH-1:0]       tail_q;
    logic                   head_v;
    logic                   tail_v;
    logic                   push;
    logic                   pop;

    assign req_s = sync_q[SYNC_STAGES-1];
    // Full is judged on the pre-pop occupancy, so a push at occupancy 2 waits one cycle.
    assign push  = (state == ST_IDLE) && req_s && !tail_v;
    assign pop   = head_v && bus.out_ready;

    // Resetting high keeps a req left over from an interrupted handshake from looking new.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], bus.req};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_RESYNC;
            ack_q <= 1'b0;
        end else begin
            case (state)
                ST_RESYNC: begin
                    if (!req_s) state <= ST_IDLE;
                end
                ST_IDLE: begin
                    if (push) begin
                        state <= ST_HOLD;
                        ack_q <= 1'b1;
                    end
                end
                ST_HOLD: begin
                    if (!req_s) begin
                        state <= ST_IDLE;
                        ack_q <= 1'b0;
                    end
                end
                default: begin
                    state <= ST_RESYNC;
                    ack_q <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_count <= '0;
        end else if (push) begin
            rx_count <= rx_count + 1'b1;
        end
    end

    // Head register drives out_data directly; tail holds the second token when full.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head_q <= '0;
            tail_q <= '0;
            head_v <= 1'b0;
            tail_v <= 1'b0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (!head_v) begin
                        head_q <= bus.data;
                        head_v <= 1'b1;
                    end else begin
                        tail_q <= bus.data;
                        tail_v <= 1'b1;
                    end
                end
                2'b01: begin
                    if (tail_v) begin
                        head_q <= tail_q;
                        tail_v <= 1'b0;
                    end else begin
                        head_v <= 1'b0;
                    end
                end
                2'b11: begin
                    head_q <= bus.data;
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.ack       = ack_q;
    assign bus.out_data  = head_q;
    assign bus.out_valid = head_v;

endmodule

// File: tb/tb_p4bd_sync_receiver.sv
// tb/tb_p4bd_sync_receiver.sv - self-checking bench for p4bd_sync_receiver
module tb_p4bd_sync_receiver;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    p4bd_sync_receiver_if #(.WIDTH(12)) b ();
    p4bd_sync_receiver_if #(.WIDTH(12)) b4 ();
    logic [15:0] rx_count;
    logic [3:0]  rx_count4;

    p4bd_sync_receiver #(.WIDTH(12), .SYNC_STAGES(2), .CNT_W(16)) dut (
        .clk(clk), .reset(reset), .bus(b.slave), .rx_count(rx_count)
    );
    p4bd_sync_receiver #(.WIDTH(12), .SYNC_STAGES(4), .CNT_W(4)) dut4 (
        .clk(clk), .reset(reset), .bus(b4.slave), .rx_count(rx_count4)
    );

    typedef struct {
        logic [11:0] d;
        int          exp_lat;
        int          exp_cnt;
    } vec_t;

    int          checks   = 0;
    int          failures = 0;
    logic [11:0] exp_q[$];
    int          model_cnt  = 0;
    int          model4_cnt = 0;
    bit          rdy_rand   = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Consumer model: every pop must deliver the oldest acked, not-yet-delivered token.
    always @(negedge clk) begin
        if (!reset && b.out_valid && b.out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL pop_unexpected actual=%0h required=no_token", b.out_data);
            end else begin
                chk("pop_data", b.out_data, exp_q.pop_front());
            end
        end
    end

    always @(posedge clk) begin
        if (rdy_rand) begin
            #1;
            b.out_ready = 1'($urandom_range(0, 1));
        end
    end

    function automatic logic get_ack(input bit sel);
        return sel ? b4.ack : b.ack;
    endfunction

    task automatic wait_ack(input bit sel, input logic level, output int n);
        n = 0;
        while (get_ack(sel) !== level && n >= 0) begin
            @(posedge clk);
            #1;
            n++;
            if (n > 300 && get_ack(sel) !== level) n = -1;
        end
    endtask

    task automatic send(input bit sel, input logic [11:0] d, output int up, output int dn);
        if (sel) begin b4.data = d; b4.req = 1'b1; end
        else     begin b.data  = d; b.req  = 1'b1; end
        wait_ack(sel, 1'b1, up);
        if (up > 0) begin
            if (sel) model4_cnt++;
            else begin exp_q.push_back(d); model_cnt++; end
        end
        if (sel) b4.req = 1'b0; else b.req = 1'b0;
        wait_ack(sel, 1'b0, dn);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        reset = 1'b1;
        exp_q.delete();
        model_cnt = 0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (4) @(posedge clk);
        #1;
    endtask

    vec_t vecs[6];
    int   up, dn, n;

    initial begin
        vecs[0] = '{12'h000, 3, 2};
        vecs[1] = '{12'hFFF, 3, 3};
        vecs[2] = '{12'h5A5, 3, 4};
        vecs[3] = '{12'h800, 3, 5};
        vecs[4] = '{12'h001, 3, 6};
        vecs[5] = '{12'h7FE, 3, 7};

        reset = 1'b1;
        b.req = 1'b0;  b.data = '0;  b.out_ready = 1'b0;
        b4.req = 1'b0; b4.data = '0; b4.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_ack", b.ack, 0);
        chk("reset_out_valid", b.out_valid, 0);
        chk("reset_out_data", b.out_data, 0);
        chk("reset_rx_count", rx_count, 0);
        reset = 1'b0;
        repeat (4) @(posedge clk);
        #1;

        // Single token with exact edge latency and a one-cycle valid pulse
        b.out_ready = 1'b1;
        b.data = 12'h0A5;
        b.req = 1'b1;
        wait_ack(1'b0, 1'b1, up);
        exp_q.push_back(12'h0A5);
        model_cnt++;
        chk("single_ack_up_lat", up, 3);
        chk("single_out_valid", b.out_valid, 1);
        chk("single_out_data", b.out_data, 12'h0A5);
        chk("single_rx_count", rx_count, 1);
        @(posedge clk);
        #1;
        chk("single_valid_one_cycle", b.out_valid, 0);
        b.req = 1'b0;
        wait_ack(1'b0, 1'b0, dn);
        chk("single_ack_dn_lat", dn + 1, 3 + 1);

        for (int i = 0; i < 6; i++) begin
            send(1'b0, vecs[i].d, up, dn);
            chk("vec_ack_up_lat", up, vecs[i].exp_lat);
            chk("vec_ack_dn_lat", dn, vecs[i].exp_lat);
            chk("vec_rx_count", rx_count, vecs[i].exp_cnt);
            repeat (i % 3) @(posedge clk);
            #0;
        end

        // Back-pressure: two tokens fill the FIFO, the third stalls until out_ready rises
        b.out_ready = 1'b0;
        send(1'b0, 12'h001, up, dn);
        chk("bp_tok1_up", up, 3);
        send(1'b0, 12'h002, up, dn);
        chk("bp_tok2_up", up, 3);
        b.data = 12'h003;
        b.req = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        chk("bp_ack_stalled", b.ack, (exp_q.size() >= 2) ? 0 : 1);
        chk("bp_head_valid", b.out_valid, 1);
        chk("bp_head_data", b.out_data, exp_q[0]);
        chk("bp_rx_count", rx_count, model_cnt);
        b.out_ready = 1'b1;
        wait_ack(1'b0, 1'b1, n);
        chk("bp_ack_resumes", n > 0, 1);
        if (n > 0) begin exp_q.push_back(12'h003); model_cnt++; end
        b.req = 1'b0;
        wait_ack(1'b0, 1'b0, dn);
        repeat (4) @(posedge clk);
        #1;
        chk("bp_drained", exp_q.size(), 0);
        chk("bp_rx_count_final", rx_count, 10);

        // 100 random tokens with out_ready held high
        do_reset();
        for (int i = 0; i < 100; i++) begin
            send(1'b0, 12'($urandom), up, dn);
            chk("rand_ack_up_lat", up, 3);
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #0;
        end
        repeat (4) @(posedge clk);
        #1;
        chk("rand_rx_count", rx_count, 100);
        chk("rand_rx_model", rx_count, model_cnt);
        chk("rand_no_loss", exp_q.size(), 0);

        // Random out_ready exercises full, stall and simultaneous push/pop
        rdy_rand = 1'b1;
        for (int i = 0; i < 60; i++) begin
            send(1'b0, 12'($urandom), up, dn);
            chk("rrdy_ack_up", up > 0, 1);
            chk("rrdy_ack_dn", dn >= 0, 1);
        end
        rdy_rand = 1'b0;
        @(posedge clk);
        #2;
        b.out_ready = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        chk("rrdy_rx_model", rx_count, 16'(model_cnt));
        chk("rrdy_no_loss", exp_q.size(), 0);

        // Reset in HOLD with req still high
        b.out_ready = 1'b0;
        b.data = 12'h777;
        b.req = 1'b1;
        wait_ack(1'b0, 1'b1, up);
        chk("mid_ack_up", up, 3);
        @(posedge clk);
        #1;
        reset = 1'b1;
        exp_q.delete();
        model_cnt = 0;
        #1;
        chk("mid_ack_drop", b.ack, 0);
        chk("mid_out_valid", b.out_valid, 0);
        chk("mid_rx_count", rx_count, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        chk("mid_no_reaccept_ack", b.ack, 0);
        chk("mid_no_reaccept_cnt", rx_count, 0);
        chk("mid_no_reaccept_valid", b.out_valid, 0);
        b.req = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        b.out_ready = 1'b1;
        send(1'b0, 12'h03C, up, dn);
        chk("mid_new_token_up", up, 3);
        chk("mid_new_rx_count", rx_count, 1);
        repeat (3) @(posedge clk);
        #1;
        chk("mid_drained", exp_q.size(), 0);

        // SYNC_STAGES=4 latency and CNT_W=4 wrap on the second instance
        for (int i = 0; i < 17; i++) begin
            send(1'b1, 12'(i), up, dn);
            if (i == 0 || i == 16) begin
                chk("s4_ack_up_lat", up, 5);
                chk("s4_ack_dn_lat", dn, 5);
            end
        end
        chk("s4_rx_count_wrap", rx_count4, model4_cnt % 16);
        chk("s4_rx_count_one", rx_count4, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
